// File: rtl/if_inst_queue_pkg.sv
// rtl/if_inst_queue_pkg.sv - shared defaults and entry type for the IF/ID instruction queue
package if_inst_queue_pkg;

    localparam int IQ_DEPTH = 4;
    localparam int IQ_DW    = 32;

    // One fetched instruction as it crosses the IF/ID boundary.
    typedef struct packed {
        logic [IQ_DW-1:0] pc;
        logic [IQ_DW-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_queue_ptr.sv
// rtl/if_queue_ptr.sv - wrapping pointer register with synchronous clear and increment enable
module if_queue_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Wrap is implicit: the queue depth is a power of two equal to 2**W.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/if_inst_queue.sv
// rtl/if_inst_queue.sv - IF-to-ID instruction queue; IF_INST_QUEUE_BYPASS_EN enables zero-latency pass-through when empty
module if_inst_queue
    import if_inst_queue_pkg::*;
#(
    parameter  int DEPTH = IQ_DEPTH,
    parameter  int DW    = IQ_DW,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_pc,
    input  logic [DW-1:0] in_inst,
    output logic          freeze,
    input  logic          flush,
    output logic          out_valid,
    output logic [DW-1:0] out_pc,
    output logic [DW-1:0] out_inst,
    input  logic          id_ready,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign freeze   = full;
    assign count    = cnt;
    assign wr_entry = '{pc: IQ_DW'(in_pc), inst: IQ_DW'(in_inst)};
    assign head     = mem[rd_ptr];
    assign pop      = ~empty & id_ready & ~flush;

`ifdef IF_INST_QUEUE_BYPASS_EN
    logic bypass;

    // An entry consumed straight through never touches the array.
    assign bypass    = empty & in_valid & ~flush;
    assign push      = in_valid & ~full & ~flush & ~(bypass & id_ready);
    assign out_valid = ~empty | bypass;
    assign out_pc    = empty ? (bypass ? in_pc   : '0) : DW'(head.pc);
    assign out_inst  = empty ? (bypass ? in_inst : '0) : DW'(head.inst);
`else
    assign push      = in_valid & ~full & ~flush;
    assign out_valid = ~empty;
    assign out_pc    = empty ? '0 : DW'(head.pc);
    assign out_inst  = empty ? '0 : DW'(head.inst);
`endif

    if_queue_ptr #(.W(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    if_queue_ptr #(.W(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    // Array is left unreset; outputs are gated on empty so stale data never escapes.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= '0;
        end else if (push && !pop) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !push) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_if_inst_queue.sv
// tb/tb_if_inst_queue.sv - scoreboard bench for if_inst_queue
module tb_if_inst_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_pc = '0;
    logic [DW-1:0] in_inst = '0;
    logic          flush = 1'b0;
    logic          id_ready = 1'b0;
    logic          freeze;
    logic          out_valid;
    logic [DW-1:0] out_pc;
    logic [DW-1:0] out_inst;
    logic [CW-1:0] count;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    logic [2*DW-1:0] sb [$];

    if_inst_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .freeze    (freeze),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .id_ready  (id_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every handshake against the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [2*DW-1:0] e;
            chk("mon_out_valid", 64'(out_valid), 64'(sb.size() != 0));
            chk("mon_freeze", 64'(freeze), 64'(sb.size() == DEPTH));
            if (out_valid && id_ready && !flush && !rst) begin
                if (sb.size() == 0) begin
                    chk("mon_unexpected_pop", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("mon_out_pc", 64'(out_pc), 64'(e[2*DW-1:DW]));
                    chk("mon_out_inst", 64'(out_inst), 64'(e[DW-1:0]));
                end
            end
        end
    end

    task automatic cycle(input bit v, input logic [DW-1:0] pc, input logic [DW-1:0] inst,
                         input bit rdy, input bit fl);
        bit acc;
        bit pre;
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst;
        id_ready = rdy;
        flush    = fl;
        acc = v && !fl && (sb.size() < DEPTH);
        pre = 1'b0;
`ifdef IF_INST_QUEUE_BYPASS_EN
        if (acc && sb.size() == 0) begin
            sb.push_back({pc, inst});
            pre = 1'b1;
        end
`endif
        @(posedge clk);
        if (fl) sb.delete();
        else if (acc && !pre) sb.push_back({pc, inst});
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_pc"}, 64'(out_pc), 64'd0);
        chk({tag, "_out_inst"}, 64'(out_inst), 64'd0);
        chk({tag, "_freeze"}, 64'(freeze), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b0);
        chk_reset_outputs("reset");

        // Fill without consuming.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, DW'(4 * (i + 1)), 32'hE000_0001 + DW'(i), 1'b0, 1'b0);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_freeze", 64'(freeze), 64'd1);
        cycle(1'b1, 32'h14, 32'hE000_0005, 1'b0, 1'b0);
        chk("full_reject_count", 64'(count), 64'd4);
        chk("full_reject_head", 64'(out_pc), 64'h4);

        // Push while full is rejected even with a simultaneous pop.
        cycle(1'b1, 32'h14, 32'hE000_0005, 1'b1, 1'b0);
        chk("full_pop_count", 64'(count), 64'd3);
        chk("full_pop_head", 64'(out_pc), 64'h8);
        chk("full_pop_freeze", 64'(freeze), 64'd0);

        // Continuous streaming across pointer wrap.
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 32'h14 + DW'(4 * i), 32'hE000_0005 + DW'(i), 1'b1, 1'b0);
        chk("stream_count", 64'(count), 64'd3);
        chk("stream_head", 64'(out_pc), 64'h30);
        chk("stream_head_inst", 64'(out_inst), 64'hE000_000C);

        // Flush beats push and pop.
        cycle(1'b1, 32'h3C, 32'hE000_000F, 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_freeze", 64'(freeze), 64'd0);
        chk("flush_out_pc", 64'(out_pc), 64'd0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("empty_ready_count", 64'(count), 64'd0);

        cycle(1'b1, 32'h40, 32'hE000_0010, 1'b0, 1'b0);
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_pc", 64'(out_pc), 64'h40);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain_count", 64'(count), 64'd0);

        // Reset mid-stream with a full queue.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h44 + DW'(4 * i), 32'hE000_0011 + DW'(i), 1'b0, 1'b0);
        chk("refill_freeze", 64'(freeze), 64'd1);
        in_valid = 1'b1;
        in_pc    = 32'h54;
        in_inst  = 32'hE000_0015;
        id_ready = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        sb.delete();
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_reset_outputs("midreset");

`ifdef IF_INST_QUEUE_BYPASS_EN
        in_valid = 1'b1;
        in_pc    = 32'h20;
        in_inst  = 32'hE000_0020;
        id_ready = 1'b1;
        sb.push_back({in_pc, in_inst});
        #1;
        chk("bypass_valid", 64'(out_valid), 64'd1);
        chk("bypass_pc", 64'(out_pc), 64'h20);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        id_ready = 1'b0;
        chk("bypass_count", 64'(count), 64'd0);
`endif

        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
